// File: rtl/start_tx_pkg.sv
// Shared types and parameter checks for the start pulse transmitter.
package start_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } tx_state_t;

  // True when the parameter set can be built: non-zero phases/depth and a counter wide enough.
  function automatic bit params_ok(input int high_cycles, input int low_cycles,
                                   input int pend_depth, input int cnt_w);
    int longest;
    longest = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return (high_cycles >= 1) && (low_cycles >= 1) && (pend_depth >= 1) &&
           (cnt_w >= 1) && (cnt_w < 31) && ((32'sd1 << cnt_w) > longest);
  endfunction

endpackage

// File: rtl/start_pulse_transmitter_phase_counter.sv
// Loadable down-counter shared by the HIGH and LOW phases; holds at zero.
module phase_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Phase count: clear wins, then load, then count down until zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign count = cnt_r;
  assign zero  = (cnt_r == '0);

endmodule

// File: rtl/start_pulse_transmitter.sv
// Shapes start requests into HIGH/LOW waveforms on startData, queueing requests that arrive mid-waveform.
module start_pulse_transmitter
  import start_tx_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_DEPTH  = 3,
  parameter int CNT_W       = 4
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            start_req,
  input  logic                            clear,
  output logic                            startData,
  output logic                            busy,
  output logic [$clog2(PEND_DEPTH+1)-1:0] pending,
  output logic                            overflow,
  output logic                            done
);

  localparam int PW = $clog2(PEND_DEPTH + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_HIGH = HIGH;
  localparam logic [1:0] ST_LOW  = LOW;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PW-1:0]    PEND_MAX  = PW'(PEND_DEPTH);
  localparam logic [PW-1:0]    PEND_ONE  = PW'(1);

  if (!params_ok(HIGH_CYCLES, LOW_CYCLES, PEND_DEPTH, CNT_W)) begin : g_bad_params
    $error("start_pulse_transmitter: illegal parameter combination");
  end

  logic [1:0]       state_r, state_s;
  logic [PW-1:0]    pend_r, pend_s;
  logic             ovf_r, ovf_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             load_s, consume_s, want_s, has_pend_s, zero_s;
  logic [CNT_W-1:0] load_val_s, cnt_s;

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (clear),
    .load     (load_s),
    .load_val (load_val_s),
    .count    (cnt_s),
    .zero     (zero_s)
  );

  // Next state, counter reload and request consumption.
  always_comb begin
    has_pend_s = (pend_r != '0);
    want_s     = start_req | has_pend_s;
    state_s    = state_r;
    load_s     = 1'b0;
    load_val_s = HIGH_LOAD;
    consume_s  = 1'b0;
    if (clear) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (want_s) begin
            state_s   = ST_HIGH;
            load_s    = 1'b1;
            consume_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (zero_s) begin
            state_s    = ST_LOW;
            load_s     = 1'b1;
            load_val_s = LOW_LOAD;
          end else begin
            state_s = ST_HIGH;
          end
        end
        ST_LOW: begin
          if (zero_s && want_s) begin
            state_s   = ST_HIGH;
            load_s    = 1'b1;
            consume_s = 1'b1;
          end else if (zero_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_LOW;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Pending queue and sticky overflow; a consumed request paired with a new one leaves the count alone.
  always_comb begin
    pend_s = pend_r;
    ovf_s  = ovf_r;
    if (clear) begin
      pend_s = '0;
      ovf_s  = 1'b0;
    end else if (consume_s) begin
      if (has_pend_s && !start_req) begin
        pend_s = pend_r - PEND_ONE;
      end else begin
        pend_s = pend_r;
      end
    end else if (start_req) begin
      if (pend_r == PEND_MAX) begin
        ovf_s = 1'b1;
      end else begin
        pend_s = pend_r + PEND_ONE;
      end
    end else begin
      pend_s = pend_r;
    end
  end

  // done marks the cycle whose counter value will be zero while in LOW.
  always_comb begin
    busy_s = (state_s != ST_IDLE);
    if (state_s == ST_LOW) begin
      done_s = load_s ? (load_val_s == '0) : (cnt_s == CNT_ONE);
    end else begin
      done_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
      pend_r  <= '0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign startData = state_r[0];
  assign busy      = busy_r;
  assign pending   = pend_r;
  assign overflow  = ovf_r;
  assign done      = done_r;

endmodule

// File: tb/tb_start_pulse_transmitter.sv
// Bench for start_pulse_transmitter: waveform-position reference model plus directed scenarios and random traffic.
module tb_start_pulse_transmitter;

  localparam int H = 4;
  localparam int L = 2;
  localparam int D = 3;
  localparam int PERIOD = H + L;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start_req = 1'b0;
  logic       clear = 1'b0;
  logic       startData, busy, overflow, done;
  logic [1:0] pending;

  int tests = 0;
  int fails = 0;
  int edges = 0;
  logic prev_sd = 1'b0;
  bit chk_en = 1'b0;

  // Reference: position within the current waveform (0 = idle, 1..PERIOD), queued count, sticky flag.
  int m_pos = 0;
  int m_pend = 0;
  bit m_ovf = 1'b0;
  bit m_can_start, m_consume;

  always #5 clk = ~clk;

  start_pulse_transmitter #(
    .HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_DEPTH(D), .CNT_W(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start_req(start_req), .clear(clear),
    .startData(startData), .busy(busy), .pending(pending),
    .overflow(overflow), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_pos = 0; m_pend = 0; m_ovf = 1'b0;
    end else if (clear) begin
      m_pos = 0; m_pend = 0; m_ovf = 1'b0;
    end else begin
      m_can_start = (m_pos == 0) || (m_pos == PERIOD);
      m_consume   = m_can_start && (start_req || m_pend > 0);
      if (m_consume) begin
        m_pos = 1;
        if (m_pend > 0 && !start_req) m_pend--;
      end else begin
        m_pos = m_can_start ? 0 : m_pos + 1;
        if (start_req) begin
          if (m_pend == D) m_ovf = 1'b1;
          else m_pend++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && n_rst) begin
      check("model_startData", startData, (m_pos >= 1 && m_pos <= H));
      check("model_busy", busy, (m_pos != 0));
      check("model_done", done, (m_pos == PERIOD));
      check("model_pending", pending, m_pend);
      check("model_overflow", overflow, m_ovf);
    end
    if (startData === 1'b1 && prev_sd === 1'b0) edges++;
    prev_sd = startData;
  end

  task automatic step(input logic r, input logic c);
    start_req = r;
    clear = c;
    @(negedge clk);
    start_req = 1'b0;
    clear = 1'b0;
  endtask

  task automatic single_req(input string tag);
    logic [7:0] sd_seq, dn_seq, bz_seq;
    int e0;
    sd_seq = 8'h00; dn_seq = 8'h00; bz_seq = 8'h00;
    e0 = edges;
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sd_seq = {sd_seq[6:0], startData};
      dn_seq = {dn_seq[6:0], done};
      bz_seq = {bz_seq[6:0], busy};
      if (i < 7) step(1'b0, 1'b0);
    end
    check({tag, "_startData_seq"}, sd_seq, 8'hF0);
    check({tag, "_done_seq"}, dn_seq, 8'h04);
    check({tag, "_busy_seq"}, bz_seq, 8'hFC);
    check({tag, "_edges"}, edges - e0, 1);
  endtask

  initial begin
    logic [7:0] pseq;
    int e0;
    repeat (3) @(negedge clk);
    check("reset_startData", startData, 0);
    check("reset_busy", busy, 0);
    check("reset_pending", pending, 0);
    check("reset_overflow", overflow, 0);
    check("reset_done", done, 0);
    n_rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) step(1'b0, 1'b0);

    single_req("single");

    e0 = edges;
    pseq = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      pseq = {pseq[5:0], pending};
    end
    check("four_pending_seq", pseq, 8'h1B);
    repeat (30) step(1'b0, 1'b0);
    check("four_edges", edges - e0, 4);
    check("four_overflow", overflow, 0);

    e0 = edges;
    repeat (5) step(1'b1, 1'b0);
    check("five_overflow_set", overflow, 1);
    check("five_pending_full", pending, 3);
    repeat (30) step(1'b0, 1'b0);
    check("five_edges", edges - e0, 4);
    check("five_overflow_sticky", overflow, 1);
    step(1'b0, 1'b1);
    check("five_overflow_cleared", overflow, 0);

    e0 = edges;
    repeat (3) step(1'b1, 1'b0);
    check("clr_pre_pending", pending, 2);
    check("clr_pre_high", startData, 1);
    step(1'b0, 1'b1);
    check("clr_startData", startData, 0);
    check("clr_pending", pending, 0);
    check("clr_overflow", overflow, 0);
    check("clr_busy", busy, 0);
    repeat (20) step(1'b0, 1'b0);
    check("clr_edges", edges - e0, 1);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    check("same_done", done, 1);
    check("same_pre_pending", pending, 1);
    step(1'b1, 1'b0);
    check("same_pending", pending, 1);
    check("same_high", startData, 1);
    repeat (20) step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    check("rst_pre_busy", busy, 1);
    #2 n_rst = 1'b0;
    #1;
    check("rst_async_startData", startData, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_pending", pending, 0);
    check("rst_async_overflow", overflow, 0);
    check("rst_async_done", done, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    single_req("after_rst");

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
    end
    repeat (30) step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
